// File: rtl/prod_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prod_accumulator                                                |
// | Purpose  : Sums VEC_LEN multiplier products per result, valid/ready on     |
// |            both sides. Optional macro PROD_ACC_SAT_EN: saturating adds.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module prod_accumulator #(
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       prod,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [7:0]       elem_cnt
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [7:0] c_LAST = 8'(VEC_LEN - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out_sum;
    logic [7:0]       r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_ovf;
    logic             r_out_ovf;

    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_add_res;
    logic             w_carry;
    logic             w_accept;
    logic             w_last;

    assign w_accept = in_valid && r_in_ready && (r_state == ST_ACCUM);
    assign w_last   = (r_cnt == c_LAST);
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, prod};
    assign w_carry  = w_sum[ACC_W];

`ifdef PROD_ACC_SAT_EN
    // A clamped accumulator carries again on any non-zero add, so it stays pinned.
    assign w_add_res = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_add_res = w_sum[ACC_W-1:0];
`endif

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_accept && w_last) w_state_next = ST_DONE;
                ST_DONE:  if (out_ready)          w_state_next = ST_ACCUM;
                default:                          w_state_next = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else if (clr) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_last) begin
                            r_out_sum   <= w_add_res;
                            r_out_ovf   <= r_ovf | w_carry;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_ovf       <= 1'b0;
                        end else begin
                            r_acc <= w_add_res;
                            r_cnt <= r_cnt + 8'd1;
                            r_ovf <= r_ovf | w_carry;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign elem_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prod_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_prod_accumulator                                             |
// | Purpose  : Self-checking bench for prod_accumulator (default and 8-bit     |
// |            overflow configurations). Honours PROD_ACC_SAT_EN.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_prod_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] prod = 8'd0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_ovf;
    logic [9:0] out_sum;
    logic [7:0] elem_cnt;

    logic       b_clr = 1'b0;
    logic       b_in_valid = 1'b0;
    logic [7:0] b_prod = 8'd0;
    logic       b_out_ready = 1'b1;
    logic       b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0] b_out_sum;
    logic [7:0] b_elem_cnt;

    prod_accumulator #(.VEC_LEN(4), .ACC_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .prod(prod),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .elem_cnt(elem_cnt)
    );

    prod_accumulator #(.VEC_LEN(2), .ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .prod(b_prod),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf), .elem_cnt(b_elem_cnt)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    typedef struct packed {
        logic [3:0][7:0] p;
        logic [9:0]      sum;
        logic            ovf;
    } vec_t;

    vec_t tbl [5];

    function automatic vec_t mk(input logic [7:0] a, b, c, d, input logic [9:0] s, input logic o);
        vec_t v;
        v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
        v.sum = s; v.ovf = o;
        return v;
    endfunction

    // Reference: true arithmetic sum, then wrap or clamp to the result width.
    function automatic void model(input int unsigned s, input int accw,
                                  output int unsigned es, output logic eo);
        int unsigned mx;
        mx = (32'd1 << accw) - 32'd1;
        eo = (s > mx);
`ifdef PROD_ACC_SAT_EN
        es = eo ? mx : s;
`else
        es = s & mx;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds prod on the input until an edge sees in_ready high, with a cycle budget.
    task automatic send(input logic [7:0] p);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        prod = p;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 20);
        if (!acc) begin
            ntests++;
            nfail++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 20 cycles");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned s, es;
        logic        eo;
        logic [7:0]  p0, p1;

        tbl[0] = mk(8'd1,   8'd4,   8'd9,   8'd16,  10'd30,  1'b0);
        tbl[1] = mk(8'd225, 8'd225, 8'd225, 8'd225, 10'd900, 1'b0);
        tbl[2] = mk(8'd0,   8'd0,   8'd0,   8'd0,   10'd0,   1'b0);
        tbl[3] = mk(8'd0,   8'd225, 8'd0,   8'd1,   10'd226, 1'b0);
        tbl[4] = mk(8'd100, 8'd200, 8'd255, 8'd255, 10'd810, 1'b0);

        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_elem_cnt", elem_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_exit_in_ready_low", in_ready, 0);
        tick();
        check("rst_exit_in_ready_high", in_ready, 1);

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) send(tbl[i].p[j]);
            check($sformatf("tbl%0d_out_valid", i), out_valid, 1);
            check($sformatf("tbl%0d_out_sum", i), out_sum, tbl[i].sum);
            check($sformatf("tbl%0d_out_ovf", i), out_ovf, tbl[i].ovf);
            check($sformatf("tbl%0d_in_ready_low", i), in_ready, 0);
            tick();
            check($sformatf("tbl%0d_released", i), out_valid, 0);
            check($sformatf("tbl%0d_in_ready_back", i), in_ready, 1);
        end

        // Backpressure: result held, inputs ignored while DONE.
        out_ready = 1'b0;
        repeat (4) send(8'd225);
        check("bp_out_valid", out_valid, 1);
        in_valid = 1'b1;
        prod = 8'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_sum_c%0d", k), out_sum, 900);
            check($sformatf("bp_valid_c%0d", k), out_valid, 1);
            check($sformatf("bp_in_ready_c%0d", k), in_ready, 0);
            check($sformatf("bp_elem_cnt_c%0d", k), elem_cnt, 0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_elem_cnt", elem_cnt, 0);

        // Gaps between elements.
        send(8'd7);  check("gap_cnt1", elem_cnt, 1);
        tick(); tick();
        send(8'd8);  check("gap_cnt2", elem_cnt, 2);
        tick();
        send(8'd9);  check("gap_cnt3", elem_cnt, 3);
        send(8'd10); check("gap_cnt0", elem_cnt, 0);
        check("gap_valid", out_valid, 1);
        check("gap_sum", out_sum, 34);
        tick();

        // clr mid-vector drops partial sum and the product offered with it.
        send(8'd100);
        send(8'd50);
        clr = 1'b1; in_valid = 1'b1; prod = 8'd200;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_elem_cnt", elem_cnt, 0);
        check("clr_in_ready", in_ready, 1);
        repeat (4) send(8'd2);
        check("clr_after_sum", out_sum, 8);
        check("clr_after_valid", out_valid, 1);
        tick();

        // clr while a result waits.
        out_ready = 1'b0;
        repeat (4) send(8'd1);
        check("clr_done_valid_before", out_valid, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_done_valid_after", out_valid, 0);
        check("clr_done_in_ready", in_ready, 1);

        // Asynchronous reset mid-vector.
        out_ready = 1'b1;
        repeat (3) send(8'd9);
        check("rstmid_cnt_before", elem_cnt, 3);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_elem_cnt", elem_cnt, 0);
        check("rstmid_in_ready", in_ready, 0);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_sum", out_sum, 0);
        check("rstmid_out_ovf", out_ovf, 0);
        #1 rst_n = 1'b1;
        tick();
        check("rstmid_in_ready_back", in_ready, 1);
        repeat (4) send(8'd5);
        check("rstmid_vec_sum", out_sum, 20);
        check("rstmid_vec_valid", out_valid, 1);
        tick();

        // Overflow on the 8-bit, 2-element instance.
        check("b_in_ready", b_in_ready, 1);
        b_in_valid = 1'b1; b_prod = 8'd225;
        tick(); tick();
        b_in_valid = 1'b0;
        model(450, 8, es, eo);
        check("b_ovf_valid", b_out_valid, 1);
`ifdef PROD_ACC_SAT_EN
        check("b_ovf_sum", b_out_sum, 255);
`else
        check("b_ovf_sum", b_out_sum, 194);
`endif
        check("b_ovf_flag", b_out_ovf, 1);
        tick();
        for (int v = 0; v < 12; v++) begin
            p0 = 8'($urandom_range(0, 255));
            p1 = 8'($urandom_range(0, 255));
            b_in_valid = 1'b1; b_prod = p0;
            tick();
            b_prod = p1;
            tick();
            b_in_valid = 1'b0;
            model(int'(p0) + int'(p1), 8, es, eo);
            check($sformatf("b_rand%0d_valid", v), b_out_valid, 1);
            check($sformatf("b_rand%0d_sum", v), b_out_sum, es);
            check($sformatf("b_rand%0d_ovf", v), b_out_ovf, eo);
            tick();
        end

        // Randomized vectors with gaps and result stalls.
        for (int v = 0; v < 30; v++) begin
            out_ready = 1'b0;
            s = 0;
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (v % 3 == 0) p0 = 8'($urandom_range(0, 255));
                else            p0 = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
                s += p0;
                send(p0);
            end
            model(s, 10, es, eo);
            check($sformatf("rand%0d_valid", v), out_valid, 1);
            check($sformatf("rand%0d_sum", v), out_sum, es);
            check($sformatf("rand%0d_ovf", v), out_ovf, eo);
            repeat ($urandom_range(0, 3)) begin
                tick();
                check($sformatf("rand%0d_hold", v), out_sum, es);
            end
            out_ready = 1'b1;
            tick();
            check($sformatf("rand%0d_release", v), out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
